// File: rtl/input_logic_pkg.sv
// Shared types and constants for the front-panel input stage.
package input_logic_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_DONE, WAIT_RELEASE} in_state_t;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus hold-time debouncer for one active-low push-button.
module key_debounce
    import input_logic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_meta;
    logic             key_sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_meta  <= 1'b1;
            key_sync  <= 1'b1;
            key_level <= 1'b1;
            cnt       <= '0;
        end else begin
            key_meta <= key_raw;
            key_sync <= key_meta;
            // Any return to the settled level restarts the hold timer.
            if (key_sync == key_level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                key_level <= key_sync;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/input_logic.sv
// Front-panel input stage: switch capture, debounced RUN/PEEK keys, one RUN pulse per press.
module input_logic
    import input_logic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] SW,
    input  logic       KEY_RUN,
    input  logic       KEY_PEEK,
    input  logic       DONE,
    output logic [9:0] DIN,
    output logic       RUN,
    output logic       PEEKb,
    output logic       BUSY
);
    logic [9:0] sw_meta;
    logic [9:0] sw_sync;
    logic       run_level;
    logic       peek_level;
    logic       run_prev;
    logic       run_next;
    in_state_t  state;
    in_state_t  next_state;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_raw   (KEY_RUN),
        .key_level (run_level)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_peek_key (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_raw   (KEY_PEEK),
        .key_level (peek_level)
    );

    always_comb begin
        next_state = state;
        run_next   = 1'b0;
        case (state)
            IDLE: begin
                // Falling edge of the debounced active-low key is a press.
                if (run_prev && !run_level) begin
                    run_next   = 1'b1;
                    next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (DONE) next_state = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (run_level) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sw_meta  <= '0;
            sw_sync  <= '0;
            run_prev <= 1'b1;
            RUN      <= 1'b0;
            DIN      <= '0;
            PEEKb    <= 1'b1;
        end else begin
            state    <= next_state;
            sw_meta  <= SW;
            sw_sync  <= sw_meta;
            run_prev <= run_level;
            RUN      <= run_next;
            PEEKb    <= peek_level;
            if (run_next) DIN <= sw_sync;
        end
    end

    assign BUSY = (state != IDLE);
endmodule

// File: tb/tb_input_logic.sv
// Bench for input_logic: directed test-plan steps followed by random key/switch/DONE traffic.
module tb_input_logic;
    localparam int DB = 4;
    localparam int NH = 8192;

    logic       clk;
    logic       rst_n;
    logic [9:0] SW;
    logic       KEY_RUN;
    logic       KEY_PEEK;
    logic       DONE;
    logic [9:0] DIN;
    logic       RUN;
    logic       PEEKb;
    logic       BUSY;

    input_logic #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SW       (SW),
        .KEY_RUN  (KEY_RUN),
        .KEY_PEEK (KEY_PEEK),
        .DONE     (DONE),
        .DIN      (DIN),
        .RUN      (RUN),
        .PEEKb    (PEEKb),
        .BUSY     (BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: raw samples per edge, and the panel's behaviour in plain terms.
    logic       kh_run  [NH];
    logic       kh_peek [NH];
    logic [9:0] swh     [NH];
    int         k;
    int         m_phase;   // 0 idle, 1 waiting for DONE, 2 waiting for release
    logic       m_run;
    logic [9:0] m_din;
    logic       m_peek;
    logic       m_prev;
    logic       m_db_run;
    logic       m_db_peek;
    int         run_count;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Debounced level flips once the synchronized key has disagreed with it for DB straight edges.
    function automatic logic settles(input bit peek, input logic db);
        logic all_diff;
        logic s;
        all_diff = 1'b1;
        for (int i = 0; i < DB; i++) begin
            s = peek ? kh_peek[k-2-i] : kh_run[k-2-i];
            if (s === db) all_diff = 1'b0;
        end
        return all_diff;
    endfunction

    task automatic tick();
        logic press;
        logic nd_run;
        logic nd_peek;
        @(posedge clk);
        k++;
        if (!rst_n) begin
            kh_run[k-1] = 1'b1;  kh_run[k] = 1'b1;
            kh_peek[k-1] = 1'b1; kh_peek[k] = 1'b1;
            swh[k-1] = '0;       swh[k] = '0;
            m_phase = 0; m_run = 1'b0; m_din = '0; m_peek = 1'b1;
            m_prev = 1'b1; m_db_run = 1'b1; m_db_peek = 1'b1;
        end else begin
            kh_run[k]  = KEY_RUN;
            kh_peek[k] = KEY_PEEK;
            swh[k]     = SW;
            press = m_prev && !m_db_run;
            m_run = 1'b0;
            if (m_phase == 0) begin
                if (press) begin
                    m_run = 1'b1;
                    m_din = swh[k-2];
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (DONE) m_phase = 2;
            end else begin
                if (m_db_run) m_phase = 0;
            end
            m_peek  = m_db_peek;
            nd_run  = settles(1'b0, m_db_run)  ? ~m_db_run  : m_db_run;
            nd_peek = settles(1'b1, m_db_peek) ? ~m_db_peek : m_db_peek;
            m_prev    = m_db_run;
            m_db_run  = nd_run;
            m_db_peek = nd_peek;
        end
        #1;
        check("din",   16'(DIN),   16'(m_din));
        check("run",   16'(RUN),   16'(m_run));
        check("busy",  16'(BUSY),  16'(m_phase != 0));
        check("peekb", 16'(PEEKb), 16'(m_peek));
        if (RUN === 1'b1) run_count++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int lat;
        int run_hold;
        int peek_hold;
        for (int i = 0; i < NH; i++) begin
            kh_run[i] = 1'b1; kh_peek[i] = 1'b1; swh[i] = '0;
        end
        k = 8;
        m_phase = 0; m_run = 1'b0; m_din = '0; m_peek = 1'b1;
        m_prev = 1'b1; m_db_run = 1'b1; m_db_peek = 1'b1;
        run_count = 0;
        rst_n = 1'b0; SW = '0; KEY_RUN = 1'b1; KEY_PEEK = 1'b1; DONE = 1'b0;

        // Reset
        ticks(2);
        check("rst_din",   16'(DIN),   16'h000);
        check("rst_run",   16'(RUN),   16'h0);
        check("rst_busy",  16'(BUSY),  16'h0);
        check("rst_peekb", 16'(PEEKb), 16'h1);
        rst_n = 1'b1;
        ticks(3);

        // First press: one RUN six edges after the key is first sampled
        SW = 10'h2A5; KEY_RUN = 1'b0; run_count = 0; lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (RUN === 1'b1 && lat < 0) lat = i - 1;
        end
        check("press_lat",   16'(lat),       16'd6);
        check("press_count", 16'(run_count), 16'd1);
        check("press_din",   16'(DIN),       16'h2A5);
        check("press_busy",  16'(BUSY),      16'h1);

        // Second press while waiting for DONE is ignored
        SW = 10'h0F0; KEY_RUN = 1'b1; ticks(8);
        KEY_RUN = 1'b0; run_count = 0; ticks(8);
        check("ignored_count", 16'(run_count), 16'd0);
        check("ignored_din",   16'(DIN),       16'h2A5);
        check("ignored_busy",  16'(BUSY),      16'h1);
        DONE = 1'b1; tick(); DONE = 1'b0;
        KEY_RUN = 1'b1; ticks(8);
        check("release_busy", 16'(BUSY), 16'h0);
        KEY_RUN = 1'b0; run_count = 0; ticks(8);
        check("second_count", 16'(run_count), 16'd1);
        check("second_din",   16'(DIN),       16'h0F0);
        DONE = 1'b1; tick(); DONE = 1'b0;
        KEY_RUN = 1'b1; ticks(8);
        check("second_idle", 16'(BUSY), 16'h0);

        // Bouncing key never settles
        run_count = 0;
        for (int i = 0; i < 10; i++) begin
            KEY_RUN = (i % 2 == 0) ? 1'b0 : 1'b1;
            ticks(2);
        end
        KEY_RUN = 1'b1; ticks(8);
        check("bounce_count", 16'(run_count), 16'd0);
        check("bounce_busy",  16'(BUSY),      16'h0);

        // PEEK follows its own debouncer, FSM untouched
        KEY_PEEK = 1'b0; lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (PEEKb === 1'b0 && lat < 0) lat = i - 1;
        end
        check("peek_press_lat", 16'(lat), 16'd6);
        KEY_PEEK = 1'b1; lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (PEEKb === 1'b1 && lat < 0) lat = i - 1;
        end
        check("peek_release_lat", 16'(lat),       16'd6);
        check("peek_run_count",   16'(run_count), 16'd0);
        check("peek_busy",        16'(BUSY),      16'h0);

        // Reset while busy with the key held
        SW = 10'h155; KEY_RUN = 1'b0; ticks(8);
        check("pre_rst_busy", 16'(BUSY), 16'h1);
        rst_n = 1'b0; ticks(2);
        check("mid_rst_din",  16'(DIN),  16'h000);
        check("mid_rst_busy", 16'(BUSY), 16'h0);
        rst_n = 1'b1; run_count = 0; lat = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (RUN === 1'b1 && lat < 0) lat = i - 1;
        end
        check("post_rst_count", 16'(run_count), 16'd1);
        check("post_rst_lat",   16'(lat),       16'd6);
        check("post_rst_din",   16'(DIN),       16'h155);
        DONE = 1'b1; tick(); DONE = 1'b0;
        KEY_RUN = 1'b1; ticks(8);

        // Random traffic against the model
        run_hold = 0; peek_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            SW = 10'($urandom);
            if (run_hold == 0) begin
                KEY_RUN  = 1'($urandom);
                run_hold = $urandom_range(1, 12);
            end
            if (peek_hold == 0) begin
                KEY_PEEK  = 1'($urandom);
                peek_hold = $urandom_range(1, 12);
            end
            run_hold--;
            peek_hold--;
            DONE  = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
